// File: rtl/coef_load_ctrl_pkg.sv
// Shared constants and types for the coefficient-memory loader: host opcodes,
// controller state encoding and the byte framing of one coefficient word.
package coef_load_pkg;

    localparam int BYTES_PER_WORD = 5;
    localparam int SHIFT_W        = 8 * BYTES_PER_WORD;

    localparam logic [7:0] OP_WR_L = 8'hA0;
    localparam logic [7:0] OP_WR_R = 8'hA1;
    localparam logic [7:0] OP_RD_L = 8'hA2;
    localparam logic [7:0] OP_RD_R = 8'hA3;

    localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_WORD - 1);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR_H    = 4'd1,
        ST_ADDR_L    = 4'd2,
        ST_CNT_H     = 4'd3,
        ST_CNT_L     = 4'd4,
        ST_WR_DATA   = 4'd5,
        ST_WR_STROBE = 4'd6,
        ST_RD_WAIT   = 4'd7,
        ST_RD_CAP    = 4'd8,
        ST_RD_SEND   = 4'd9
    } state_e;

    // The four opcodes share their upper six bits; bit 1 selects read, bit 0 the right channel.
    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WR_L) || (b == OP_WR_R) || (b == OP_RD_L) || (b == OP_RD_R);
    endfunction

endpackage

// File: rtl/coef_load_ctrl_if.sv
// Host byte link plus the coefficient RAM left/right read-write ports.
// The master modport is the loader side; slave is the host link / RAM side.
interface coef_load_ctrl_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 36
);

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    logic [ADDR_W-1:0] addrLrw;
    logic [ADDR_W-1:0] addrRrw;
    logic [DATA_W-1:0] datainLrw;
    logic [DATA_W-1:0] datainRrw;
    logic              weL;
    logic              weR;
    logic [DATA_W-1:0] dataoutLrw;
    logic [DATA_W-1:0] dataoutRrw;

    modport master (
        input  rx_data, rx_valid, tx_ready, dataoutLrw, dataoutRrw,
        output rx_ready, tx_data, tx_valid,
        output addrLrw, addrRrw, datainLrw, datainRrw, weL, weR
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, dataoutLrw, dataoutRrw,
        input  rx_ready, tx_data, tx_valid,
        input  addrLrw, addrRrw, datainLrw, datainRrw, weL, weR
    );

endinterface

// File: rtl/coef_load_ctrl.sv
// Byte-stream loader for the stereo FIR coefficient RAM: parses opcode/address/count
// headers, then writes 36-bit words or reads them back as 5-byte bursts.
module coef_load_ctrl
    import coef_load_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 36,
    parameter int CNT_W  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    abort,
    coef_load_ctrl_if.master        bus,
    output logic                    busy,
    output logic                    done,
    output logic                    cmd_err
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;        // words remaining minus one
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [2:0]         byte_cnt_q, byte_cnt_d;
    logic [1:0]         op_q, op_d;          // [1]=read, [0]=right channel
    logic               weL_q, weL_d;
    logic               weR_q, weR_d;
    logic               done_q, done_d;
    logic               cmd_err_q, cmd_err_d;

    logic rx_take;
    logic tx_take;
    logic last_word;

    assign rx_take   = bus.rx_valid && bus.rx_ready;
    assign tx_take   = bus.tx_valid && bus.tx_ready;
    assign last_word = (cnt_q == '0);

    // NOTE: the reset here is synchronous, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            op_q       <= '0;
            weL_q      <= 1'b0;
            weR_q      <= 1'b0;
            done_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the pre-edge values.
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            op_q       <= op_d;
            weL_q      <= weL_d;
            weR_q      <= weR_d;
            done_q     <= done_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path can infer a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        op_d       = op_q;
        done_d     = 1'b0;
        cmd_err_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_take) begin
                    if (is_opcode(bus.rx_data)) begin
                        op_d    = bus.rx_data[1:0];
                        state_d = ST_ADDR_H;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_ADDR_H: begin
                if (rx_take) begin
                    addr_d[ADDR_W-1:8] = bus.rx_data[ADDR_W-9:0];
                    state_d            = ST_ADDR_L;
                end
            end
            ST_ADDR_L: begin
                if (rx_take) begin
                    addr_d[7:0] = bus.rx_data;
                    state_d     = ST_CNT_H;
                end
            end
            ST_CNT_H: begin
                if (rx_take) begin
                    cnt_d[CNT_W-1:8] = bus.rx_data;
                    state_d          = ST_CNT_L;
                end
            end
            ST_CNT_L: begin
                if (rx_take) begin
                    cnt_d[7:0] = bus.rx_data;
                    byte_cnt_d = '0;
                    state_d    = op_q[1] ? ST_RD_WAIT : ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (rx_take) begin
                    shift_d = {shift_q[SHIFT_W-9:0], bus.rx_data};
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        state_d    = ST_WR_STROBE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end
            ST_WR_STROBE: begin
                addr_d = addr_q + 1'b1;
                if (last_word) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = ST_WR_DATA;
                end
            end
            ST_RD_WAIT: begin
                state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                shift_d    = {{(SHIFT_W-DATA_W){1'b0}}, op_q[0] ? bus.dataoutRrw : bus.dataoutLrw};
                byte_cnt_d = '0;
                state_d    = ST_RD_SEND;
            end
            ST_RD_SEND: begin
                if (tx_take) begin
                    shift_d = {shift_q[SHIFT_W-9:0], 8'h00};
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        addr_d     = addr_q + 1'b1;
                        if (last_word) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d   = cnt_q - 1'b1;
                            state_d = ST_RD_WAIT;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over everything except a strobe already registered for this cycle.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end

        weL_d = (state_d == ST_WR_STROBE) && !op_q[0];
        weR_d = (state_d == ST_WR_STROBE) &&  op_q[0];
    end

    assign bus.rx_ready  = (state_q == ST_IDLE)  || (state_q == ST_ADDR_H) ||
                           (state_q == ST_ADDR_L) || (state_q == ST_CNT_H) ||
                           (state_q == ST_CNT_L)  || (state_q == ST_WR_DATA);
    assign bus.tx_valid  = (state_q == ST_RD_SEND);
    assign bus.tx_data   = shift_q[SHIFT_W-1:SHIFT_W-8];

    assign bus.addrLrw   = addr_q;
    assign bus.addrRrw   = addr_q;
    assign bus.datainLrw = shift_q[DATA_W-1:0];
    assign bus.datainRrw = shift_q[DATA_W-1:0];
    assign bus.weL       = weL_q;
    assign bus.weR       = weR_q;

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign cmd_err = cmd_err_q;

endmodule
